// File: rtl/ex_stage_mc.sv
// Registered execute stage: forwarding muxes, single-cycle ALU, iterative MUL/DIVU/REMU,
// and a valid/ready output register that lets the hazard unit stall upstream.
module ex_stage_mc #(
    parameter int W    = 16,
    parameter int NFWD = 2,
    parameter int RW   = 4,
    parameter int SELW = $clog2(NFWD + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      pc_in,
    input  logic [3:0]        alu_op,
    input  logic [RW-1:0]     rd,
    input  logic [W-1:0]      rs1_data,
    input  logic [W-1:0]      rs2_data,
    input  logic [W-1:0]      imm,
    input  logic              alu_src,
    input  logic [SELW-1:0]   forward_a,
    input  logic [SELW-1:0]   forward_b,
    input  logic [NFWD*W-1:0] fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      alu_result,
    output logic              zero,
    output logic [W-1:0]      branch_target,
    output logic [RW-1:0]     rd_out,
    output logic              busy
);

    localparam int SHW = $clog2(W);
    localparam int CW  = $clog2(W);

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_out_valid;
    logic [W-1:0]    r_result;
    logic            r_zero;
    logic [W-1:0]    r_bt;
    logic [RW-1:0]   r_rd;

    logic [3:0]      r_mc_op;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_mcand;
    logic [W-1:0]    r_mplier;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quo;
    logic [W-1:0]    r_dvsr;
    logic [W-1:0]    r_mc_bt;
    logic [RW-1:0]   r_mc_rd;

    logic [W-1:0]    w_opa;
    logic [W-1:0]    w_opb;
    logic [W-1:0]    w_alu;
    logic [W-1:0]    w_bt;
    logic [W-1:0]    w_mc_res;
    logic [W:0]      w_rem_sh;
    logic            w_qbit;
    logic            w_out_free;
    logic            w_accept;
    logic            w_is_mc;
    logic            w_divz;
    logic            w_iterate;

    function automatic logic [W-1:0] fwd_mux(input logic [SELW-1:0]   sel,
                                             input logic [W-1:0]      reg_data,
                                             input logic [NFWD*W-1:0] fwd);
        logic [W-1:0] v;
        v = reg_data;
        for (int k = 1; k <= NFWD; k++) begin
            if (int'(sel) == k) v = fwd[k*W-1 -: W];
        end
        return v;
    endfunction

    // Divide-by-zero results are produced here so they complete like single-cycle ops.
    function automatic logic [W-1:0] alu_1c(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[SHW-1:0];
            4'd6:    r = a >> b[SHW-1:0];
            4'd7:    r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:    r = '1;
            4'd10:   r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign w_opa      = fwd_mux(forward_a, rs1_data, fwd_data);
    assign w_opb      = alu_src ? imm : fwd_mux(forward_b, rs2_data, fwd_data);
    assign w_alu      = alu_1c(alu_op, w_opa, w_opb);
    assign w_bt       = pc_in + imm;
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == ST_IDLE) && w_out_free;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_is_mc    = (alu_op == 4'd8) || (alu_op == 4'd9) || (alu_op == 4'd10);
    assign w_divz     = ((alu_op == 4'd9) || (alu_op == 4'd10)) && (w_opb == '0);
    assign w_iterate  = w_is_mc && !w_divz;

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh = {r_rem, r_quo[W-1]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_dvsr});

    always_comb begin
        w_mc_res = r_rem;
        if (r_mc_op == 4'd8)      w_mc_res = r_acc;
        else if (r_mc_op == 4'd9) w_mc_res = r_quo;
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_iterate) begin
            r_mc_op  <= alu_op;
            r_acc    <= '0;
            r_mcand  <= w_opa;
            r_mplier <= w_opb;
            r_rem    <= '0;
            r_quo    <= w_opa;
            r_dvsr   <= w_opb;
            r_mc_bt  <= w_bt;
            r_mc_rd  <= rd;
        end else if (r_state == ST_ITER) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_qbit ? W'(w_rem_sh - {1'b0, r_dvsr}) : w_rem_sh[W-1:0];
            r_quo    <= {r_quo[W-2:0], w_qbit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_bt        <= '0;
            r_rd        <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (out_ready) r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_iterate) begin
                        r_state <= ST_ITER;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_result    <= w_alu;
                        r_zero      <= (w_alu == '0);
                        r_bt        <= w_bt;
                        r_rd        <= rd;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ITER: begin
                    if (r_cnt == CW'(W - 1)) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_out_free) begin
                        r_result    <= w_mc_res;
                        r_zero      <= (w_mc_res == '0);
                        r_bt        <= r_mc_bt;
                        r_rd        <= r_mc_rd;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign alu_result    = r_result;
    assign zero          = r_zero;
    assign branch_target = r_bt;
    assign rd_out        = r_rd;
    assign busy          = (r_state == ST_ITER);

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: directed timing/boundary cases, then randomized ops
// with random backpressure checked against an arithmetic reference model.
module tb_ex_stage_mc;

    localparam int W    = 16;
    localparam int NFWD = 2;
    localparam int RW   = 4;
    localparam int SELW = 2;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready;
    logic [W-1:0]      pc_in, rs1_data, rs2_data, imm;
    logic [3:0]        alu_op;
    logic [RW-1:0]     rd;
    logic              alu_src;
    logic [SELW-1:0]   forward_a, forward_b;
    logic [NFWD*W-1:0] fwd_data;
    logic              out_valid, out_ready, zero, busy;
    logic [W-1:0]      alu_result, branch_target;
    logic [RW-1:0]     rd_out;

    logic dir_ready, rnd_ready, rand_mode;
    assign out_ready = rand_mode ? rnd_ready : dir_ready;

    ex_stage_mc #(.W(W), .NFWD(NFWD), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .alu_op(alu_op), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .alu_src(alu_src), .forward_a(forward_a), .forward_b(forward_b),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
        .rd_out(rd_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic          z;
        logic [W-1:0]  bt;
        logic [RW-1:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned ua, ub;
        int sa, sb;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        case (op)
            4'd0:    return W'(ua + ub);
            4'd1:    return W'(ua - ub);
            4'd2:    return W'(ua & ub);
            4'd3:    return W'(ua | ub);
            4'd4:    return W'(ua ^ ub);
            4'd5:    return W'(ua << (ub % W));
            4'd6:    return W'(ua >> (ub % W));
            4'd7:    return (sa < sb) ? W'(1) : W'(0);
            4'd8:    return W'(ua * ub);
            4'd9:    return (ub == 0) ? {W{1'b1}} : W'(ua / ub);
            4'd10:   return (ub == 0) ? a : W'(ua % ub);
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] pick(input logic [SELW-1:0] sel, input logic [W-1:0] r,
                                          input logic [NFWD*W-1:0] f);
        int s;
        s = int'(sel);
        if (s >= 1 && s <= NFWD) return f[s*W-1 -: W];
        return r;
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        logic [W-1:0] a, b;
        a = pick(forward_a, rs1_data, fwd_data);
        b = alu_src ? imm : pick(forward_b, rs2_data, fwd_data);
        e.res = ref_alu(alu_op, a, b);
        e.z   = (e.res == '0);
        e.bt  = W'(pc_in + imm);
        e.rd  = rd;
        return e;
    endfunction

    always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

    // Monitor: every completed output handshake is matched against the oldest expectation.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got 0x%0h, expected no output", alu_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", alu_result, e.res);
                check("sb_zero", zero, e.z);
                check("sb_branch_target", branch_target, e.bt);
                check("sb_rd_out", rd_out, e.rd);
            end
        end
    end

    task automatic scramble();
        rs1_data = W'($urandom); rs2_data = W'($urandom); imm = W'($urandom);
        pc_in = W'($urandom); fwd_data = $urandom; alu_op = 4'($urandom);
        rd = RW'($urandom); forward_a = SELW'($urandom); forward_b = SELW'($urandom);
        alu_src = 1'($urandom);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a_reg, input logic [W-1:0] b_reg,
                         input logic [W-1:0] im, input logic [W-1:0] pc, input logic src,
                         input logic [SELW-1:0] fa, input logic [SELW-1:0] fb,
                         input logic [NFWD*W-1:0] fwd, input logic [RW-1:0] d, input bit expect_out);
        int waitc;
        waitc = 0;
        @(negedge clk);
        alu_op = op; rs1_data = a_reg; rs2_data = b_reg; imm = im; pc_in = pc;
        alu_src = src; forward_a = fa; forward_b = fb; fwd_data = fwd; rd = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        if (expect_out) sb_q.push_back(make_exp());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // Counts edges after the accepting edge until out_valid rises.
    task automatic measure(output int lat, output int nbusy, output int nstall);
        lat = 0; nbusy = 0; nstall = 0;
        while (!out_valid && lat < 100) begin
            nbusy  += int'(busy);
            nstall += int'(!in_ready);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, ns;
        logic [W-1:0] held;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; dir_ready = 1'b1; rand_mode = 1'b0;
        scramble();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_result", alu_result, 0);
        check("rst_zero", zero, 1);
        check("rst_branch_target", branch_target, 0);
        check("rst_rd_out", rd_out, 0);
        check("rst_in_ready", in_ready, 1);

        issue(4'd0, 16'h7FFF, 16'h0001, 16'h0004, 16'hFFFE, 1'b0, 2'd0, 2'd0, 32'h0, 4'd5, 1);
        measure(lat, nb, ns);
        check("add_latency", lat, 0);
        check("add_result", alu_result, 16'h8000);
        check("add_zero", zero, 0);
        check("add_branch_wrap", branch_target, 16'h0002);

        issue(4'd1, 16'h0000, 16'h0234, 16'h0, 16'h0100, 1'b0, 2'd2, 2'd0, {16'h1234, 16'hAAAA}, 4'd3, 1);
        check("fwd_slice1_sub", alu_result, 16'h1000);
        issue(4'd0, 16'h0042, 16'h0001, 16'h0, 16'h0, 1'b0, 2'd3, 2'd0, {16'h1234, 16'h5555}, 4'd2, 1);
        check("fwd_sel_oob", alu_result, 16'h0043);
        issue(4'd1, 16'h5A5A, 16'h5A5A, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd1, 1);
        check("sub_zero_flag", zero, 1);

        issue(4'd8, 16'h00FF, 16'h0101, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd4, 1);
        measure(lat, nb, ns);
        check("mul_latency", lat, 17);
        check("mul_busy_cycles", nb, 16);
        check("mul_stall_cycles", ns, 17);
        check("mul_result", alu_result, 16'hFFFF);

        issue(4'd9, 16'd100, 16'd7, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd6, 1);
        measure(lat, nb, ns);
        check("divu_latency", lat, 17);
        check("divu_result", alu_result, 16'd14);
        issue(4'd10, 16'd100, 16'd7, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd6, 1);
        measure(lat, nb, ns);
        check("remu_result", alu_result, 16'd2);
        issue(4'd9, 16'h1234, 16'd0, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd7, 1);
        measure(lat, nb, ns);
        check("divz_latency", lat, 0);
        check("divz_result", alu_result, 16'hFFFF);
        issue(4'd10, 16'd5, 16'd0, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd7, 1);
        measure(lat, nb, ns);
        check("remz_latency", lat, 0);
        check("remz_result", alu_result, 16'd5);

        // Backpressure: hold a result, present another op, then release.
        @(posedge clk);
        #1;
        dir_ready = 1'b0;
        issue(4'd0, 16'd3, 16'd4, 16'h0, 16'h0010, 1'b0, 2'd0, 2'd0, 32'h0, 4'd8, 1);
        held = alu_result;
        check("bp_first_result", held, 16'd7);
        @(negedge clk);
        alu_op = 4'd4; rs1_data = 16'hF0F0; rs2_data = 16'h0FF0; alu_src = 1'b0;
        forward_a = 2'd0; forward_b = 2'd0; imm = 16'h0; pc_in = 16'h0020; rd = 4'd9;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready_low", in_ready, 0);
            check("bp_result_stable", alu_result, held);
            check("bp_valid_held", out_valid, 1);
            @(negedge clk);
        end
        dir_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        sb_q.push_back(make_exp());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_result", alu_result, 16'hFF00);

        // Flush mid-divide: nothing may be emitted.
        @(posedge clk);
        #1;
        issue(4'd9, 16'hFFFF, 16'd3, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd10, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        repeat (25) @(posedge clk);
        #1;
        check("flush_no_result", out_valid, 0);

        // Asynchronous reset mid-multiply clears stale outputs before any clock edge.
        issue(4'd8, 16'd3, 16'd5, 16'h0, 16'h0, 1'b0, 2'd0, 2'd0, 32'h0, 4'd11, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_alu_result", alu_result, 0);
        check("arst_zero", zero, 1);
        check("arst_branch_target", branch_target, 0);
        check("arst_rd_out", rd_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            issue(4'($urandom_range(0, 15)), a, b, W'($urandom), W'($urandom), 1'($urandom),
                  SELW'($urandom), SELW'($urandom), $urandom, RW'($urandom), 1);
        end
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_scoreboard", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised, registered execute stage that succeeds the single-cycle EX1 stage. It applies the same operand-forwarding selection over a configurable number of bypass sources and executes single-cycle ALU ops. It adds iterative multi-cycle multiply, unsigned divide and unsigned remainder. Results, zero flag, branch target and destination register are held in an output pipeline register behind a valid/ready handshake, so the hazard unit can stall upstream while a long op is in flight.

## Interface
Parameters:
- `W`, 16, datapath width (≥4)
- `NFWD`, 2, number of forwarding sources
- `RW`, 4, register-index width
- `SELW`, `$clog2(NFWD+1)`, forwarding-select width (derived, not overridden)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous kill of in-flight op and output register
- `in_valid`  in  1  ID/EX presents an instruction
- `in_ready`  out  1  stage accepts this cycle
- `pc_in`  in  W  instruction PC
- `alu_op`  in  4  operation code (see Operation)
- `rd`  in  RW  destination register
- `rs1_data`, `rs2_data`, `imm`  in  W each  register-file operands and immediate
- `alu_src`  in  1  0 = operand B from rs2 path, 1 = imm
- `forward_a`, `forward_b`  in  SELW each  0 = register data, k (1..NFWD) = `fwd_data` slice k-1
- `fwd_data`  in  NFWD*W  bypass values; slice k-1 occupies bits [k*W-1:(k-1)*W]
- `out_valid`  out  1  output register holds a result
- `out_ready`  in  1  downstream consumes result
- `alu_result`  out  W  registered result
- `zero`  out  1  registered (`alu_result`==0)
- `branch_target`  out  W  registered `pc_in + imm`, mod 2^W
- `rd_out`  out  RW  registered `rd`
- `busy`  out  1  multi-cycle unit iterating

## Operation
- Operand A = mux(`forward_a`). Operand B = `alu_src` ? `imm` : mux(`forward_b`). Select values above NFWD fall back to register data.
- Operands, `rd`, and the branch target are sampled only at acceptance (`in_valid && in_ready`). Later changes to inputs or `fwd_data` do not affect the in-flight op.
- Single-cycle ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL and 6 SRL shift by B[$clog2(W)-1:0].
  - 7 SLT is signed; result 1 or 0.
  - Codes 11–15: result 0.
  - All arithmetic wraps mod 2^W.
- Multi-cycle ops:
  - 8 MUL: low W bits of A*B, shift-add, one bit per cycle.
  - 9 DIVU: quotient; 10 REMU: remainder. Both restoring, one bit per cycle.
  - Divide by zero: quotient = all ones, remainder = A. Completes single-cycle with no iteration.
- States: IDLE, ITER (counter runs 0..W-1), DONE. IDLE→ITER on accepting op 8/9/10 with nonzero divisor (MUL always iterates). ITER→DONE when counter = W-1. DONE→IDLE when the result loads into the output register.
- `in_ready` = (state==IDLE) && (!`out_valid` || `out_ready`).
- Output register:
  - Loads on single-cycle accept, or in DONE when (!`out_valid` || `out_ready`).
  - Clears `out_valid` on `out_ready` when no new load occurs.
  - DONE holds until the output register can load.
- `flush`: state→IDLE, counter→0, `out_valid`→0. Has priority over acceptance the same cycle.
- Reset values: `out_valid`=0, `busy`=0, `alu_result`=0, `zero`=1, `branch_target`=0, `rd_out`=0, state=IDLE. `in_ready` is 1 after reset.

## Timing
- Single-cycle op: accept at edge N; `out_valid`=1 with result after edge N.
- MUL / DIVU / REMU: accept at edge N; `busy`=1 after N through edge N+W; result visible after edge N+W+1, i.e. latency W+1. `in_ready`=0 throughout.
- Back-to-back single-cycle ops with `out_ready`=1: one result per cycle.
- `out_ready`=0 with `out_valid`=1: all outputs are stable and `in_ready`=0.
- Asserting `rst_n` low mid-iteration takes effect immediately. Partial results are discarded.

## Test plan
- Reset, then ADD with A=0x7FFF, B=1 (W=16) → `alu_result`=0x8000, `zero`=0, one cycle after accept. `branch_target` = `pc_in`+`imm` wraps: `pc_in`=0xFFFE, `imm`=4 → 0x0002.
- Forwarding: `forward_a`=2, `fwd_data` slice1=0x1234, `rs1_data`=0, SUB B=0x0234 → 0x1000. A select value of 3 with NFWD=2 uses `rs1_data`.
- MUL 0x00FF×0x0101 → 0xFFFF after exactly 17 cycles. `in_ready` is low for those cycles and `busy` high for 16.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU x/0 → 0xFFFF and REMU 5/0 → 5, both with single-cycle latency.
- Backpressure: hold `out_ready`=0 while a result is valid and present another op → `in_ready`=0 and outputs unchanged. Release → next op accepted that cycle.
- `flush` at cycle 5 of a DIVU → `busy`=0 and `out_valid`=0 next cycle, no result emitted. Asserting `rst_n` low mid-MUL clears all outputs asynchronously.
